// File: rtl/tqvp_vga_pkg.sv
// Shared VGA timing constants for the 1024x768 @ 64 MHz mode.
// Used by the console and by the sync generator.
package tqvp_vga_pkg;

    localparam int H_VISIBLE = 1024;
    localparam int H_FP      = 24;
    localparam int H_SYNC    = 136;
    localparam int H_BP      = 160;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_VISIBLE = 768;
    localparam int V_FP      = 3;
    localparam int V_SYNC    = 6;
    localparam int V_BP      = 29;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int X_LO_W = 5;
    localparam int X_HI_W = 6;
    localparam int X_LO_N = 32;
    localparam int Y_LO_W = 6;
    localparam int Y_HI_W = 5;
    localparam int Y_LO_N = 48;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    // Elaboration-time only: splits a constant into hi/lo fields.
    function automatic int split_hi(input int v, input int n);
        return v / n;
    endfunction

    function automatic int split_lo(input int v, input int n);
        return v % n;
    endfunction

endpackage

// File: rtl/tqvp_split_counter.sv
// Two-field counter: lo counts 0..LO_N-1 and carries into hi;
// at (END_HI, END_LO) both fields return to zero.
module tqvp_split_counter
    import tqvp_vga_pkg::*;
#(
    parameter int LO_W   = 5,
    parameter int HI_W   = 6,
    parameter int LO_N   = 32,
    parameter int END_HI = 41,
    parameter int END_LO = 31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    output logic [LO_W-1:0] o_lo,
    output logic [HI_W-1:0] o_hi,
    output logic [LO_W-1:0] o_lo_nxt,
    output logic [HI_W-1:0] o_hi_nxt
);

    localparam logic [LO_W-1:0] LO_LAST = LO_W'(LO_N - 1);
    localparam logic [LO_W-1:0] E_LO    = LO_W'(END_LO);
    localparam logic [HI_W-1:0] E_HI    = HI_W'(END_HI);

    logic [LO_W-1:0] r_lo;
    logic [HI_W-1:0] r_hi;
    logic [LO_W-1:0] w_lo_n;
    logic [HI_W-1:0] w_hi_n;
    logic            w_end;

    assign w_end = (r_lo == E_LO) && (r_hi == E_HI);

    always_comb begin
        w_lo_n = r_lo;
        w_hi_n = r_hi;
        if (i_en) begin
            if (w_end) begin
                w_lo_n = '0;
                w_hi_n = '0;
            end else if (r_lo == LO_LAST) begin
                w_lo_n = '0;
                w_hi_n = r_hi + HI_W'(1);
            end else begin
                w_lo_n = r_lo + LO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo <= '0;
            r_hi <= '0;
        end else begin
            r_lo <= w_lo_n;
            r_hi <= w_hi_n;
        end
    end

    assign o_lo     = r_lo;
    assign o_hi     = r_hi;
    assign o_lo_nxt = w_lo_n;
    assign o_hi_nxt = w_hi_n;

endmodule

// File: rtl/tqvp_vga_sync_gen.sv
// VGA sync/blank generator with split x/y counters and a sticky
// vertical-blank interrupt; all flags registered from next-state counts.
module tqvp_vga_sync_gen
    import tqvp_vga_pkg::*;
#(
    parameter int H_VISIBLE = tqvp_vga_pkg::H_VISIBLE,
    parameter int H_FP      = tqvp_vga_pkg::H_FP,
    parameter int H_SYNC    = tqvp_vga_pkg::H_SYNC,
    parameter int H_BP      = tqvp_vga_pkg::H_BP,
    parameter int V_VISIBLE = tqvp_vga_pkg::V_VISIBLE,
    parameter int V_FP      = tqvp_vga_pkg::V_FP,
    parameter int V_SYNC    = tqvp_vga_pkg::V_SYNC,
    parameter int V_BP      = tqvp_vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cli,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              interrupt,
    output logic [X_LO_W-1:0] x_lo,
    output logic [X_HI_W-1:0] x_hi,
    output logic [Y_LO_W-1:0] y_lo,
    output logic [Y_HI_W-1:0] y_hi
);

    localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int XW = X_HI_W + X_LO_W;
    localparam int YW = Y_HI_W + Y_LO_W;

    localparam int HSS = H_VISIBLE + H_FP;
    localparam int HSE = HSS + H_SYNC;
    localparam int VSS = V_VISIBLE + V_FP;
    localparam int VSE = VSS + V_SYNC;

    // Split-field constants; {hi,lo} orders like the value since lo < LO_N.
    localparam logic [XW-1:0] X_HV  = {X_HI_W'(split_hi(H_VISIBLE, X_LO_N)),
                                       X_LO_W'(split_lo(H_VISIBLE, X_LO_N))};
    localparam logic [XW-1:0] X_HSS = {X_HI_W'(split_hi(HSS, X_LO_N)),
                                       X_LO_W'(split_lo(HSS, X_LO_N))};
    localparam logic [XW-1:0] X_HSE = {X_HI_W'(split_hi(HSE, X_LO_N)),
                                       X_LO_W'(split_lo(HSE, X_LO_N))};
    localparam logic [XW-1:0] X_END = {X_HI_W'(split_hi(HT - 1, X_LO_N)),
                                       X_LO_W'(split_lo(HT - 1, X_LO_N))};
    localparam logic [YW-1:0] Y_VV  = {Y_HI_W'(split_hi(V_VISIBLE, Y_LO_N)),
                                       Y_LO_W'(split_lo(V_VISIBLE, Y_LO_N))};
    localparam logic [YW-1:0] Y_VSS = {Y_HI_W'(split_hi(VSS, Y_LO_N)),
                                       Y_LO_W'(split_lo(VSS, Y_LO_N))};
    localparam logic [YW-1:0] Y_VSE = {Y_HI_W'(split_hi(VSE, Y_LO_N)),
                                       Y_LO_W'(split_lo(VSE, Y_LO_N))};

    logic [X_LO_W-1:0] w_x_lo_n;
    logic [X_HI_W-1:0] w_x_hi_n;
    logic [Y_LO_W-1:0] w_y_lo_n;
    logic [Y_HI_W-1:0] w_y_hi_n;
    logic [XW-1:0]     w_xn;
    logic [YW-1:0]     w_yn;
    logic              w_x_last;
    logic              w_set;
    sync_t             w_sync_n;
    sync_t             r_sync;
    logic              r_int;

    tqvp_split_counter #(
        .LO_W   (X_LO_W),
        .HI_W   (X_HI_W),
        .LO_N   (X_LO_N),
        .END_HI (split_hi(HT - 1, X_LO_N)),
        .END_LO (split_lo(HT - 1, X_LO_N))
    ) u_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (1'b1),
        .o_lo     (x_lo),
        .o_hi     (x_hi),
        .o_lo_nxt (w_x_lo_n),
        .o_hi_nxt (w_x_hi_n)
    );

    tqvp_split_counter #(
        .LO_W   (Y_LO_W),
        .HI_W   (Y_HI_W),
        .LO_N   (Y_LO_N),
        .END_HI (split_hi(VT - 1, Y_LO_N)),
        .END_LO (split_lo(VT - 1, Y_LO_N))
    ) u_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_x_last),
        .o_lo     (y_lo),
        .o_hi     (y_hi),
        .o_lo_nxt (w_y_lo_n),
        .o_hi_nxt (w_y_hi_n)
    );

    assign w_xn     = {w_x_hi_n, w_x_lo_n};
    assign w_yn     = {w_y_hi_n, w_y_lo_n};
    assign w_x_last = ({x_hi, x_lo} == X_END);
    assign w_set    = w_x_last && (w_yn == Y_VV);

    always_comb begin
        w_sync_n       = '0;
        w_sync_n.hsync = !((w_xn >= X_HSS) && (w_xn < X_HSE));
        w_sync_n.vsync = !((w_yn >= Y_VSS) && (w_yn < Y_VSE));
        w_sync_n.blank = (w_xn >= X_HV) || (w_yn >= Y_VV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0};
            r_int  <= 1'b0;
        end else begin
            r_sync <= w_sync_n;
            r_int  <= w_set | (r_int & ~cli);
        end
    end

    assign hsync     = r_sync.hsync;
    assign vsync     = r_sync.vsync;
    assign blank     = r_sync.blank;
    assign interrupt = r_int;

endmodule

// File: tb/tb_tqvp_vga_sync_gen.sv
// Bench: default-mode line checks plus a reduced-timing instance
// checked cycle by cycle against a reference model.
module tb_tqvp_vga_sync_gen;

    localparam int SHV = 80;
    localparam int SHF = 8;
    localparam int SHS = 12;
    localparam int SHB = 28;
    localparam int SVV = 100;
    localparam int SVF = 3;
    localparam int SVS = 6;
    localparam int SVB = 11;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;

    typedef struct packed {
        logic [5:0] xhi;
        logic [4:0] xlo;
        logic [4:0] yhi;
        logic [5:0] ylo;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       irq;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cli = 1'b0;
    logic cli_d = 1'b0;

    logic s_hs, s_vs, s_bl, s_int;
    logic [4:0] s_xlo;
    logic [5:0] s_xhi;
    logic [5:0] s_ylo;
    logic [4:0] s_yhi;
    logic d_hs, d_vs, d_bl, d_int;
    logic [4:0] d_xlo;
    logic [5:0] d_xhi;
    logic [5:0] d_ylo;
    logic [4:0] d_yhi;

    always #5 clk = ~clk;

    tqvp_vga_sync_gen #(
        .H_VISIBLE (SHV), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_VISIBLE (SVV), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .cli (cli),
        .hsync (s_hs), .vsync (s_vs), .blank (s_bl), .interrupt (s_int),
        .x_lo (s_xlo), .x_hi (s_xhi), .y_lo (s_ylo), .y_hi (s_yhi)
    );

    tqvp_vga_sync_gen u_def (
        .clk (clk), .rst_n (rst_n), .cli (cli_d),
        .hsync (d_hs), .vsync (d_vs), .blank (d_bl), .interrupt (d_int),
        .x_lo (d_xlo), .x_hi (d_xhi), .y_lo (d_ylo), .y_hi (d_yhi)
    );

    obs_t sb[$];
    int checks = 0;
    int errors = 0;
    int mx = 0;
    int my = 0;
    logic mint = 1'b0;
    int cyc = 0;
    int fall_t[$];
    int vs_len = -1;
    logic vs_prev = 1'b1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.xhi = 6'(mx / 32);
        o.xlo = 5'(mx % 32);
        o.yhi = 5'(my / 48);
        o.ylo = 6'(my % 48);
        o.hs  = !(mx >= SHV + SHF && mx < SHV + SHF + SHS);
        o.vs  = !(my >= SVV + SVF && my < SVV + SVF + SVS);
        o.bl  = (mx >= SHV) || (my >= SVV);
        o.irq = mint;
        return o;
    endfunction

    function automatic obs_t s_obs();
        return '{s_xhi, s_xlo, s_yhi, s_ylo, s_hs, s_vs, s_bl, s_int};
    endfunction

    function automatic obs_t d_obs();
        return '{d_xhi, d_xlo, d_yhi, d_ylo, d_hs, d_vs, d_bl, d_int};
    endfunction

    task automatic model_reset();
        mx = 0;
        my = 0;
        mint = 1'b0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (mx == SHT - 1 && my == SVV - 1) mint = 1'b1;
            else if (cli) mint = 1'b0;
            if (mx == SHT - 1) begin
                mx = 0;
                my = (my == SVT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
    endtask

    task automatic tick();
        obs_t e;
        model_step();
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("scan", 32'(s_obs()), 32'(e));
        if (vs_prev && !s_vs) fall_t.push_back(cyc);
        if (!vs_prev && s_vs && vs_len < 0 && fall_t.size() > 0)
            vs_len = cyc - fall_t[0];
        vs_prev = s_vs;
    endtask

    initial begin
        int hfirst;
        int hcnt;
        int found;
        int ones;
        obs_t rst_exp;

        rst_exp = '{6'd0, 5'd0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_small", 32'(s_obs()), 32'(model_obs()));
        check("rst_def", 32'(d_obs()), 32'(rst_exp));
        repeat (3) tick();
        rst_n = 1'b1;

        hfirst = -1;
        hcnt = 0;
        for (int n = 1; n <= 1344; n++) begin
            tick();
            if (n == 700)
                check("def_x700", 32'({d_xhi, d_xlo}), 32'({6'd21, 5'd28}));
            if (n == 1023) check("def_blank_1023", 32'(d_bl), 32'd0);
            if (n == 1024) check("def_blank_1024", 32'(d_bl), 32'd1);
            if (!d_hs) begin
                if (hfirst < 0) hfirst = n;
                hcnt++;
            end
        end
        check("def_line_wrap", 32'({d_xhi, d_xlo, d_yhi, d_ylo}),
              32'({6'd0, 5'd0, 5'd0, 6'd1}));
        check("def_hsync_start", 32'(hfirst), 32'd1048);
        check("def_hsync_len", 32'(hcnt), 32'd136);

        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            tick();
            if (s_yhi == 5'd2 && s_ylo == 6'd4 && s_xhi == 6'd0 && s_xlo == 5'd0)
                found = 1;
        end
        check("irq_reach", 32'(found), 32'd1);
        check("irq_set", 32'(s_int), 32'd1);
        repeat (10) tick();
        check("irq_sticky", 32'(s_int), 32'd1);
        cli = 1'b1;
        tick();
        cli = 1'b0;
        check("irq_cli_clear", 32'(s_int), 32'd0);

        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            tick();
            if (s_yhi == 5'd2 && s_ylo == 6'd3 && s_xhi == 6'd3 && s_xlo == 5'd31)
                found = 1;
        end
        check("pre_set_reach", 32'(found), 32'd1);
        cli = 1'b1;
        tick();
        check("irq_set_wins", 32'(s_int), 32'd1);
        ones = 0;
        repeat (SHT * SVT) begin
            tick();
            if (s_int) ones++;
        end
        check("cli_hold_ones", 32'(ones), 32'd1);
        check("cli_hold_set_again", 32'(s_int), 32'd1);
        cli = 1'b0;

        check("vs_falls_seen", 32'(fall_t.size() >= 2), 32'd1);
        if (fall_t.size() >= 2)
            check("frame_period", 32'(fall_t[1] - fall_t[0]), 32'(SHT * SVT));
        check("vsync_len", 32'(vs_len), 32'(SVS * SHT));

        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            tick();
            if (s_yhi == 5'd1 && s_ylo == 6'd2 && s_xhi == 6'd2 && s_xlo == 5'd6)
                found = 1;
        end
        check("midframe_reach", 32'(found), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_small", 32'(s_obs()), 32'(rst_exp));
        check("rst_mid_def", 32'(d_obs()), 32'(rst_exp));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("restart_small", 32'({s_xhi, s_xlo, s_yhi, s_ylo}),
              32'({6'd0, 5'd1, 5'd0, 6'd0}));
        check("restart_def", 32'({d_xhi, d_xlo, d_yhi, d_ylo}),
              32'({6'd0, 5'd1, 5'd0, 6'd0}));
        repeat (300) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
